// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter owner and single-outstanding instruction fetch FSM
// Optional HLT detection and HALTED state enabled by defining PC_FETCH_HALT_EN.
module pc_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc_new,
  output logic [15:0] pc_current,
  output logic [15:0] pc_plus2,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_valid,
  output logic [15:0] instruction,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        halt
);

`ifdef PC_FETCH_HALT_EN
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_HALTED} state_t;
  logic halt_q, halt_d;
`else
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
`endif

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= 16'h0000;
`ifdef PC_FETCH_HALT_EN
      halt_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
`ifdef PC_FETCH_HALT_EN
      halt_q  <= halt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
`ifdef PC_FETCH_HALT_EN
    halt_d  = halt_q;
`endif
    case (state_q)
      S_REQ: state_d = S_WAIT;
      S_WAIT: begin
        if (imem_valid) begin
          instr_d = imem_rdata;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (inst_ready) begin
`ifdef PC_FETCH_HALT_EN
          if (instr_q[15:12] == 4'hF) begin
            halt_d  = 1'b1;
            state_d = S_HALTED;
          end else begin
            pc_d    = pc_new & 16'hFFFE;
            state_d = S_REQ;
          end
`else
          pc_d    = pc_new & 16'hFFFE;
          state_d = S_REQ;
`endif
        end
      end
`ifdef PC_FETCH_HALT_EN
      S_HALTED: state_d = S_HALTED;
`endif
      default: state_d = S_REQ;
    endcase
  end

  // The reset state is REQ, so the request must be masked while rst_n is low.
  assign imem_req    = (state_q == S_REQ) && rst_n;
  assign imem_addr   = pc_q;
  assign pc_current  = pc_q;
  assign pc_plus2    = pc_q + 16'd2;
  assign instruction = instr_q;
  assign inst_valid  = (state_q == S_HOLD);
`ifdef PC_FETCH_HALT_EN
  assign halt        = halt_q;
`else
  assign halt        = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc_new;
  logic [15:0] pc_current, pc_plus2, imem_addr, imem_rdata, instruction;
  logic        imem_req, imem_valid, inst_valid, inst_ready, halt;
  int checks = 0;
  int errors = 0;

  pc_fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .pc_new(pc_new), .pc_current(pc_current),
    .pc_plus2(pc_plus2), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .instruction(instruction),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .halt(halt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in the REQ cycle; returns in the HOLD cycle with data latched.
  task automatic fetch(input logic [15:0] data, input int lat);
    for (int i = 0; i < lat; i++) step();
    imem_valid = 1'b1;
    imem_rdata = data;
    step();
    imem_valid = 1'b0;
    imem_rdata = 16'h0000;
  endtask

  task automatic accept(input logic [15:0] npc);
    inst_ready = 1'b1;
    pc_new     = npc;
    step();
    inst_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pc_new = 16'h0; imem_rdata = 16'h0; imem_valid = 1'b0; inst_ready = 1'b0;
    step(); step(); step();
    checks++;
    if (pc_current !== 16'h0000 || inst_valid !== 1'b0 || halt !== 1'b0 ||
        imem_req !== 1'b0 || instruction !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state: pc=%h iv=%b halt=%b req=%b instr=%h, expected 0000 0 0 0 0000",
               pc_current, inst_valid, halt, imem_req, instruction);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      errors++;
      $display("FAIL reset_release: req=%b addr=%h, expected 1 0000", imem_req, imem_addr);
    end
  endtask

  task automatic test_single_fetch();
    step();
    checks++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL wait_state: req=%b iv=%b, expected 0 0", imem_req, inst_valid);
    end
    fetch(16'hA123, 0);
    checks++;
    if (instruction !== 16'hA123 || inst_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_fetch: instr=%h iv=%b, expected a123 1", instruction, inst_valid);
    end
    accept(16'h0002);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0002 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_accept: req=%b addr=%h iv=%b, expected 1 0002 0", imem_req, imem_addr, inst_valid);
    end
  endtask

  task automatic test_backpressure();
    fetch(16'h1234, 1);
    for (int i = 0; i < 4; i++) begin
      imem_valid = (i == 1);
      imem_rdata = 16'hFFFF;
      step();
      checks++;
      if (instruction !== 16'h1234 || pc_current !== 16'h0002 || inst_valid !== 1'b1 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_%0d: instr=%h pc=%h iv=%b req=%b, expected 1234 0002 1 0",
                 i, instruction, pc_current, inst_valid, imem_req);
      end
    end
    imem_valid = 1'b0;
    imem_rdata = 16'h0000;
    accept(16'h0010);
    checks++;
    if (pc_current !== 16'h0010 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_accept: pc=%h req=%b, expected 0010 1", pc_current, imem_req);
    end
  endtask

  task automatic test_branch();
    fetch(16'h2000, 1);
    accept(16'h0043);
    checks++;
    if (pc_current !== 16'h0042 || imem_addr !== 16'h0042 || pc_plus2 !== 16'h0044) begin
      errors++;
      $display("FAIL branch_misalign: pc=%h addr=%h plus2=%h, expected 0042 0042 0044",
               pc_current, imem_addr, pc_plus2);
    end
    fetch(16'h3000, 3);
    accept(16'hFFFF);
    checks++;
    if (pc_current !== 16'hFFFE || pc_plus2 !== 16'h0000 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL pc_wrap: pc=%h plus2=%h req=%b, expected fffe 0000 1", pc_current, pc_plus2, imem_req);
    end
  endtask

  task automatic test_halt();
    fetch(16'hF000, 1);
    accept(16'h0100);
`ifdef PC_FETCH_HALT_EN
    checks++;
    if (halt !== 1'b1 || inst_valid !== 1'b0 || pc_current !== 16'hFFFE) begin
      errors++;
      $display("FAIL halt_enter: halt=%b iv=%b pc=%h, expected 1 0 fffe", halt, inst_valid, pc_current);
    end
    for (int i = 0; i < 10; i++) begin
      imem_valid = i[0];
      inst_ready = 1'b1;
      step();
      checks++;
      if (imem_req !== 1'b0 || halt !== 1'b1 || inst_valid !== 1'b0 || pc_current !== 16'hFFFE) begin
        errors++;
        $display("FAIL halt_hold_%0d: req=%b halt=%b iv=%b pc=%h, expected 0 1 0 fffe",
                 i, imem_req, halt, inst_valid, pc_current);
      end
    end
    imem_valid = 1'b0;
    inst_ready = 1'b0;
`else
    checks++;
    if (pc_current !== 16'h0100 || halt !== 1'b0 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL hlt_disabled: pc=%h halt=%b req=%b, expected 0100 0 1", pc_current, halt, imem_req);
    end
`endif
  endtask

  task automatic test_reset_mid_wait();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    fetch(16'h5555, 1);
    accept(16'h0020);
    step();
    checks++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0 || pc_current !== 16'h0020) begin
      errors++;
      $display("FAIL pre_reset_wait: req=%b iv=%b pc=%h, expected 0 0 0020", imem_req, inst_valid, pc_current);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (pc_current !== 16'h0000 || imem_req !== 1'b0 || inst_valid !== 1'b0 ||
        instruction !== 16'h0000 || halt !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_wait: pc=%h req=%b iv=%b instr=%h halt=%b, expected 0000 0 0 0000 0",
               pc_current, imem_req, inst_valid, instruction, halt);
    end
    step(); step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      errors++;
      $display("FAIL refetch_req: req=%b addr=%h, expected 1 0000", imem_req, imem_addr);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL refetch_idle_%0d: iv=%b req=%b, expected 0 0", i, inst_valid, imem_req);
      end
    end
    fetch(16'h6789, 0);
    checks++;
    if (inst_valid !== 1'b1 || instruction !== 16'h6789 || pc_current !== 16'h0000) begin
      errors++;
      $display("FAIL refetch_data: iv=%b instr=%h pc=%h, expected 1 6789 0000", inst_valid, instruction, pc_current);
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_backpressure();
    test_branch();
    test_halt();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
